// File: rtl/dds_sweep_ctrl.sv
// DDS table-address sweep sequencer: steps address from start to stop, strobing FreqChng,
// waiting for Oscillator Ready and dwelling per step. Replaces the rotary encoder input.
module dds_sweep_ctrl #(
  parameter int ADDR_W  = 11,
  parameter int DWELL_W = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic              Fg_clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic              Loop,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [ADDR_W-1:0] StopAddr,
  input  logic [ADDR_W-1:0] StepSize,
  input  logic [DWELL_W-1:0] Dwell,
  input  logic              Ready,
  output logic [ADDR_W-1:0] address,
  output logic              FreqChng,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, DWELL, STEP, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, start_q, start_d, stop_q, stop_d, step_q, step_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d, dcnt_q, dcnt_d;
  logic [TO_W-1:0]     tcnt_q, tcnt_d;
  logic                loop_q, loop_d, up_q, up_d, freq_q, freq_d, err_q, err_d;
  logic [ADDR_W:0]     nxt_up, nxt_dn;
  logic [ADDR_W-1:0]   nxt_addr;

  // One extra bit catches both overflow past the top and wrap below zero.
  always_comb begin
    nxt_up = {1'b0, addr_q} + {1'b0, step_q};
    nxt_dn = {1'b0, addr_q} - {1'b0, step_q};
    if (up_q)
      nxt_addr = (nxt_up > {1'b0, stop_q}) ? stop_q : nxt_up[ADDR_W-1:0];
    else
      nxt_addr = (nxt_dn[ADDR_W] || (nxt_dn[ADDR_W-1:0] < stop_q)) ? stop_q : nxt_dn[ADDR_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    loop_d  = loop_q;
    up_d    = up_q;
    dcnt_d  = dcnt_q;
    tcnt_d  = tcnt_q;
    freq_d  = 1'b0;
    err_d   = err_q;
    if (state_q != IDLE && Abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start && !Abort) begin
            start_d = StartAddr;
            stop_d  = StopAddr;
            step_d  = (StepSize == '0) ? ADDR_W'(1) : StepSize;
            dwell_d = Dwell;
            loop_d  = Loop;
            up_d    = (StopAddr >= StartAddr);
            err_d   = 1'b0;
            addr_d  = StartAddr;
            freq_d  = 1'b1;
            tcnt_d  = '0;
            state_d = WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          // Ready is stale during the strobe cycle, so only look from the next cycle on.
          if (!freq_q) begin
            if (Ready) begin
              dcnt_d  = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
              state_d = DWELL;
            end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end
        end
        DWELL: begin
          if (dcnt_q <= DWELL_W'(1)) state_d = STEP;
          else                       dcnt_d  = dcnt_q - 1'b1;
        end
        STEP: begin
          if (addr_q == stop_q && !loop_q) begin
            state_d = DONE;
          end else begin
            addr_d  = (addr_q == stop_q) ? start_q : nxt_addr;
            freq_d  = 1'b1;
            tcnt_d  = '0;
            state_d = WAIT_RDY;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Fg_clk) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      loop_q  <= 1'b0;
      up_q    <= 1'b0;
      dcnt_q  <= '0;
      tcnt_q  <= '0;
      freq_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      loop_q  <= loop_d;
      up_q    <= up_d;
      dcnt_q  <= dcnt_d;
      tcnt_q  <= tcnt_d;
      freq_q  <= freq_d;
      err_q   <= err_d;
    end
  end

  assign address  = addr_q;
  assign FreqChng = freq_q;
  assign Busy     = (state_q != IDLE) && (state_q != DONE);
  assign Done     = (state_q == DONE);
  assign Err      = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: table-driven sweeps with an address scoreboard fed by a
// reference stepping model, plus hand sequences for timeout, loop/abort and reset.
module tb_dds_sweep_ctrl;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, loop_i, ready;
  logic [AW-1:0] start_a, stop_a, step_a;
  logic [DW-1:0] dwell;
  logic [AW-1:0] address;
  logic          freq, busy, done, err;

  dds_sweep_ctrl #(.ADDR_W(AW), .DWELL_W(DW), .TIMEOUT(TO)) dut (
    .Fg_clk(clk), .Reset(rst), .Start(start), .Abort(abort), .Loop(loop_i),
    .StartAddr(start_a), .StopAddr(stop_a), .StepSize(step_a), .Dwell(dwell),
    .Ready(ready), .address(address), .FreqChng(freq), .Busy(busy), .Done(done), .Err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: expected strobe addresses in order, popped on every FreqChng.
  int   q[$];
  int   cyc = 0, last_s = -1, exp_gap = 0, done_cnt = 0, strobe_cnt = 0;
  logic prev_f = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (freq === 1'b1) begin
      strobe_cnt++;
      chk("no_back_to_back_strobe", prev_f, 0);
      if (q.size() == 0) chk("strobe_expected", 0, 1);
      else               chk("strobe_addr", address, q.pop_front());
      if (exp_gap != 0 && last_s >= 0) chk("step_period", cyc - last_s, exp_gap);
      last_s = cyc;
    end
    prev_f = freq;
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int sa, sp, st, dw;
    int n;
    int last;
  } vec_t;

  vec_t tbl[7];

  task automatic run_sweep(input vec_t v);
    int a, st, d0, s0, de;
    a  = v.sa;
    st = (v.st == 0) ? 1 : v.st;
    q.push_back(a);
    while (a != v.sp) begin
      if (v.sp >= v.sa) a = (a + st > v.sp) ? v.sp : a + st;
      else              a = (a - st < v.sp) ? v.sp : a - st;
      q.push_back(a);
    end
    de      = (v.dw == 0) ? 1 : v.dw;
    exp_gap = de + 3;
    last_s  = -1;
    d0      = done_cnt;
    s0      = strobe_cnt;
    start_a = AW'(v.sa); stop_a = AW'(v.sp); step_a = AW'(v.st); dwell = DW'(v.dw);
    loop_i  = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_clear_after_start", err, 0);
    tick();
    // Start and new config while busy must not disturb the running sweep.
    start = 1'b1; start_a = 11'd500; stop_a = 11'd600; step_a = 11'd7; loop_i = 1'b1;
    tick();
    start = 1'b0; loop_i = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    chk("done_seen", done, 1);
    chk("busy_low_with_done", busy, 0);
    chk("final_addr", address, v.last);
    chk("scoreboard_drained", q.size(), 0);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("strobe_count", strobe_cnt - s0, v.n);
    chk("addr_held_after_done", address, v.last);
    q.delete();
    exp_gap = 0;
  endtask

  initial begin
    int bad, d0;
    tbl[0] = '{sa: 10,   sp: 20,   st: 5, dw: 3, n: 3, last: 20};
    tbl[1] = '{sa: 100,  sp: 90,   st: 4, dw: 2, n: 4, last: 90};
    tbl[2] = '{sa: 5,    sp: 8,    st: 0, dw: 0, n: 4, last: 8};
    tbl[3] = '{sa: 7,    sp: 7,    st: 3, dw: 2, n: 1, last: 7};
    tbl[4] = '{sa: 2040, sp: 2047, st: 5, dw: 1, n: 3, last: 2047};
    tbl[5] = '{sa: 3,    sp: 0,    st: 2, dw: 4, n: 3, last: 0};
    tbl[6] = '{sa: 1,    sp: 0,    st: 5, dw: 1, n: 2, last: 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; loop_i = 1'b0; ready = 1'b1;
    start_a = '0; stop_a = '0; step_a = '0; dwell = '0;
    repeat (3) tick();
    chk("rst_address", address, 0);
    chk("rst_freq", freq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) run_sweep(tbl[i]);

    // Ready timeout: Busy must hold for 16 sampled cycles, then drop with Err.
    ready = 1'b0;
    q.push_back(50);
    d0 = done_cnt;
    start_a = 11'd50; stop_a = 11'd60; step_a = 11'd1; dwell = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (freq === 1'b1) break;
    end
    bad = 0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      if (busy !== 1'b1 || err !== 1'b0) bad++;
    end
    chk("busy_during_ready_wait", bad, 0);
    @(negedge clk);
    chk("timeout_busy", busy, 0);
    chk("timeout_err", err, 1);
    chk("timeout_addr_held", address, 50);
    repeat (4) @(negedge clk);
    chk("timeout_no_done", done_cnt - d0, 0);
    chk("err_sticky", err, 1);
    q.delete();
    ready = 1'b1;
    tick();
    run_sweep(tbl[0]);

    // Loop sweep, then abort mid-dwell.
    start_a = 11'd0; stop_a = 11'd2; step_a = 11'd1; dwell = 16'd3; loop_i = 1'b1;
    q.push_back(0); q.push_back(1); q.push_back(2); q.push_back(0); q.push_back(1);
    exp_gap = 6; last_s = -1;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0; loop_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("loop_wrap_strobes", q.size(), 0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_addr_held", address, 1);
    chk("abort_no_strobe", freq, 0);
    repeat (12) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_stays_idle", busy, 0);
    exp_gap = 0;

    // Start together with Abort is ignored.
    start_a = 11'd30; stop_a = 11'd40; step_a = 11'd2;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    repeat (5) tick();
    chk("start_abort_addr", address, 1);

    // Reset in the middle of a sweep.
    ready = 1'b0;
    q.push_back(0);
    start_a = 11'd0; stop_a = 11'd100; step_a = 11'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre_reset_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("midrst_address", address, 0);
    chk("midrst_freq", freq, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    rst = 1'b0;
    ready = 1'b1;
    q.delete();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
